xbar_sat_sweeper: RTL and testbench

Sequential stimulus driver and result collector that sits directly upstream of a combinational crossbar evaluation netlist and consumes its single output `f`. On `start` it walks every assignment of the crossbar's `N_VARS` primary inputs, waits a fixed settle time per assignment, and samples `f`. It reports satisfiability, the first satisfying assignment, and the number of satisfying assignments. It is the hardware check harness for synthesised crossbar netlists in the SAT flow.

---
 rtl/xbar_sat_sweeper.sv | 101 ++++++++++
 tb/tb_xbar_sat_sweeper.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/xbar_sat_sweeper.sv
// Exhaustive stimulus sweeper for a combinational crossbar netlist: drives every
// input assignment, samples f after a settle delay and collects SAT results.
module xbar_sat_sweeper #(
  parameter int N_VARS = 4,
  parameter int SETTLE = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stop_on_first,
  input  logic              abort,
  output logic [N_VARS-1:0] assign_out,
  input  logic              f_in,
  output logic              busy,
  output logic              done,
  output logic              sat,
  output logic [N_VARS-1:0] model,
  output logic [N_VARS:0]   hit_count
);

  localparam int CW = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
  localparam logic [CW-1:0] SETTLE_LD = CW'(SETTLE);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_EVAL, S_DONE} state_t;

  state_t          state, state_nx;
  logic [CW-1:0]   cnt;
  logic            sof_q;
  logic            launch;
  logic            advance;

  always_comb begin
    state_nx = state;
    launch   = 1'b0;
    advance  = 1'b0;
    unique case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          launch   = 1'b1;
          state_nx = (SETTLE == 0) ? S_EVAL : S_WAIT;
        end
      end
      S_WAIT: begin
        if (abort)                 state_nx = S_IDLE;
        else if (cnt == CW'(1))    state_nx = S_EVAL;
      end
      S_EVAL: begin
        if (abort)                 state_nx = S_IDLE;
        else if (f_in && sof_q)    state_nx = S_DONE;
        else if (&assign_out)      state_nx = S_DONE;
        else begin
          advance  = 1'b1;
          state_nx = (SETTLE == 0) ? S_EVAL : S_WAIT;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  // abort blocks every datapath update; partial results are left in place
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      assign_out <= '0;
      sat        <= 1'b0;
      model      <= '0;
      hit_count  <= '0;
      sof_q      <= 1'b0;
      cnt        <= '0;
    end else if (launch) begin
      assign_out <= '0;
      sat        <= 1'b0;
      model      <= '0;
      hit_count  <= '0;
      sof_q      <= stop_on_first;
      cnt        <= SETTLE_LD;
    end else if (state == S_WAIT && !abort) begin
      cnt <= cnt - CW'(1);
    end else if (state == S_EVAL && !abort) begin
      if (f_in) begin
        hit_count <= hit_count + (N_VARS + 1)'(1);
        if (!sat) begin
          sat   <= 1'b1;
          model <= assign_out;
        end
      end
      if (advance) begin
        assign_out <= assign_out + N_VARS'(1);
        cnt        <= SETTLE_LD;
      end
    end
  end

  assign busy = (state == S_WAIT) || (state == S_EVAL);
  assign done = (state == S_DONE);

endmodule

// File: tb/tb_xbar_sat_sweeper.sv
// Self-checking bench for xbar_sat_sweeper: crossbar stubbed by a truth table,
// outputs compared every cycle against a cycle-count based result model.
module tb_xbar_sat_sweeper;

  localparam int NV = 4;
  localparam int ST = 2;
  localparam int P  = ST + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          stop_on_first = 1'b0;
  logic          abort = 1'b0;
  logic [NV-1:0] assign_out;
  logic          f_in;
  logic          busy, done, sat;
  logic [NV-1:0] model;
  logic [NV:0]   hit_count;

  logic [15:0]   cur_tt = '0;
  logic          cur_sof = 1'b0;
  logic          launch = 1'b0;
  logic          run_active = 1'b0;
  int            c = 0;
  int            first_done;
  int            checks = 0;
  int            failures = 0;

  typedef struct packed {
    logic       busy;
    logic       done;
    logic       sat;
    logic [3:0] model;
    logic [3:0] asg;
    logic [4:0] hits;
  } exp_t;

  xbar_sat_sweeper #(.N_VARS(NV), .SETTLE(ST)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop_on_first(stop_on_first),
    .abort(abort), .assign_out(assign_out), .f_in(f_in), .busy(busy),
    .done(done), .sat(sat), .model(model), .hit_count(hit_count)
  );

  always #5 clk = ~clk;
  always_comb f_in = cur_tt[assign_out];
  always @(posedge clk) c <= launch ? 0 : c + 1;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t c=%0d)", nm, act, exp, $time, c);
    end
  endtask

  // Outputs after the c-th edge following the start edge. Each assignment takes P
  // edges; assignment j is sampled on edge P*(j+1).
  function automatic exp_t model_at(input logic [15:0] t, input logic s, input int cc);
    exp_t r;
    int first, kend, e, n;
    first = -1;
    for (int j = 0; j < 16; j++) if (t[j] && first < 0) first = j;
    kend = (s && first >= 0) ? first : 15;
    e = P * (kend + 1);
    n = (cc >= e) ? kend + 1 : cc / P;
    r = '0;
    r.busy = (cc < e);
    r.done = (cc >= e);
    r.asg  = (cc >= e) ? 4'(kend) : 4'(cc / P);
    for (int j = 0; j < n; j++) begin
      if (t[j]) begin
        r.hits = r.hits + 5'd1;
        if (!r.sat) begin
          r.sat   = 1'b1;
          r.model = 4'(j);
        end
      end
    end
    return r;
  endfunction

  always @(negedge clk) begin
    if (run_active) begin
      exp_t e;
      e = model_at(cur_tt, cur_sof, c);
      chk("busy", int'(busy), int'(e.busy));
      chk("done", int'(done), int'(e.done));
      chk("sat", int'(sat), int'(e.sat));
      chk("model", int'(model), int'(e.model));
      chk("assign_out", int'(assign_out), int'(e.asg));
      chk("hit_count", int'(hit_count), int'(e.hits));
    end
  end

  task automatic launch_sweep(input logic [15:0] t, input logic s);
    @(negedge clk);
    cur_tt = t; cur_sof = s;
    start = 1'b1; stop_on_first = s; launch = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; stop_on_first = 1'b0; launch = 1'b0;
    run_active = 1'b1;
    first_done = -1;
  endtask

  task automatic run_sweep(input logic [15:0] t, input logic s, input bit poke);
    int e_end;
    exp_t fin;
    launch_sweep(t, s);
    fin = model_at(t, s, 1000);
    e_end = 0;
    while (model_at(t, s, e_end).busy) e_end++;
    do begin
      @(negedge clk);
      if (done && first_done < 0) first_done = c;
      start = poke && (c == 10);
      stop_on_first = poke && (c == 10) && !s;
    end while (c < e_end + 1);
    #1 run_active = 1'b0;
    start = 1'b0; stop_on_first = 1'b0;
    chk("done_latency", first_done, e_end);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] rt;
    logic rs;
    repeat (3) @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_assign", int'(assign_out), 0);
    chk("rst_hits", int'(hit_count), 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_busy", int'(busy), 0);

    // single hit at 4'b1010
    run_sweep(16'h0400, 1'b0, 1'b0);
    chk("single_latency", first_done, 48);
    chk("single_sat", int'(sat), 1);
    chk("single_model", int'(model), 10);
    chk("single_hits", int'(hit_count), 1);
    chk("single_assign", int'(assign_out), 15);

    // unsat, started from DONE
    run_sweep(16'h0000, 1'b0, 1'b0);
    chk("unsat_latency", first_done, 48);
    chk("unsat_sat", int'(sat), 0);
    chk("unsat_model", int'(model), 0);
    chk("unsat_hits", int'(hit_count), 0);

    // f = assign_out[1], stop on first
    run_sweep(16'hCCCC, 1'b1, 1'b0);
    chk("sof_latency", first_done, 9);
    chk("sof_model", int'(model), 2);
    chk("sof_hits", int'(hit_count), 1);
    chk("sof_assign", int'(assign_out), 2);

    // all satisfying
    run_sweep(16'hFFFF, 1'b0, 1'b0);
    chk("all_hits", int'(hit_count), 16);
    chk("all_model", int'(model), 0);

    // start while busy must not restart or relatch stop_on_first
    run_sweep(16'h0400, 1'b0, 1'b1);
    chk("poke_latency", first_done, 48);

    // abort at cycle 20: edge 21 would have evaluated assignment 6
    launch_sweep(16'hCCCC, 1'b0);
    while (c < 20) @(negedge clk);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0; run_active = 1'b0;
    @(negedge clk);
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_assign", int'(assign_out), 6);
    chk("abort_hits", int'(hit_count), 2);
    chk("abort_model", int'(model), 2);
    repeat (4) @(negedge clk);
    chk("abort_stays_idle", int'(busy), 0);

    // async reset between edges
    launch_sweep(16'hFFFF, 1'b0);
    while (c < 15) @(negedge clk);
    run_active = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", int'(busy), 0);
    chk("arst_done", int'(done), 0);
    chk("arst_sat", int'(sat), 0);
    chk("arst_model", int'(model), 0);
    chk("arst_assign", int'(assign_out), 0);
    chk("arst_hits", int'(hit_count), 0);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("arst_idle_busy", int'(busy), 0);
    chk("arst_idle_assign", int'(assign_out), 0);

    for (int i = 0; i < 6; i++) begin
      rt = 16'($urandom);
      if (i == 2) rt = '0;
      rs = 1'($urandom_range(0, 1));
      run_sweep(rt, rs, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
